// File: rtl/para_dual.sv
// -----------------------------------------------------------------------------
// para_dual: true dual-port RAM, single clock domain.
//
// Two independent read/write ports (A and B) share one array of `depth` words.
// Each port reads every cycle with one cycle of latency, whether or not it is
// also writing. Addresses at or above `depth` never touch the array and read
// back as zero. If both ports write the same word in one cycle, port A's data
// is kept. A read on one port of a word being written by the other port
// returns the old contents.
//
// Optional feature macro: PARA_DUAL_WRITE_FIRST_EN
//   undefined (default) : same-port read-during-write returns the old word
//   defined             : same-port read-during-write returns the new data_x
//   Cross-port behaviour and the A-over-B collision rule hold in both modes.
//
// Ports:
//   clk     in   1           rising-edge clock
//   reset   in   1           asynchronous, active-low; clears q_a, q_b and
//                            every memory word while low
//   addr_a  in   addr_width  port A address
//   addr_b  in   addr_width  port B address
//   data_a  in   data_width  port A write data
//   data_b  in   data_width  port B write data
//   wr_a    in   1           port A write enable (1 = write, 0 = read)
//   wr_b    in   1           port B write enable (1 = write, 0 = read)
//   q_a     out  data_width  port A registered read data
//   q_b     out  data_width  port B registered read data
// -----------------------------------------------------------------------------
module para_dual #(
    parameter int unsigned addr_width = 6,
    parameter int unsigned data_width = 8,
    parameter int unsigned depth      = 36
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] addr_a,
    input  logic [addr_width-1:0] addr_b,
    input  logic [data_width-1:0] data_a,
    input  logic [data_width-1:0] data_b,
    input  logic                  wr_a,
    input  logic                  wr_b,
    output logic [data_width-1:0] q_a,
    output logic [data_width-1:0] q_b
);

    logic [data_width-1:0] r_mem [depth];
    logic [data_width-1:0] r_q_a;
    logic [data_width-1:0] r_q_b;

    logic                  w_a_in_range;
    logic                  w_b_in_range;
    logic                  w_same_addr;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic [data_width-1:0] w_old_a;
    logic [data_width-1:0] w_old_b;
    logic [data_width-1:0] w_rd_a;
    logic [data_width-1:0] w_rd_b;

    assign w_a_in_range = (32'(addr_a) < depth);
    assign w_b_in_range = (32'(addr_b) < depth);
    assign w_same_addr  = (addr_a == addr_b);

    // Port B loses a same-address collision, so its write is dropped entirely.
    assign w_wr_a = wr_a && w_a_in_range;
    assign w_wr_b = wr_b && w_b_in_range && !(w_wr_a && w_same_addr);

    // Array contents before this edge's writes land; this is what cross-port
    // readers always see.
    assign w_old_a = w_a_in_range ? r_mem[addr_a] : '0;
    assign w_old_b = w_b_in_range ? r_mem[addr_b] : '0;

`ifdef PARA_DUAL_WRITE_FIRST_EN
    // Write-first: a port that writes in range sees its own data_x, even when
    // port B's write is the one discarded by a collision.
    always_comb begin
        w_rd_a = w_old_a;
        w_rd_b = w_old_b;
        if (w_wr_a) begin
            w_rd_a = data_a;
        end
        if (wr_b && w_b_in_range) begin
            w_rd_b = data_b;
        end
    end
`else
    // Read-first: every port returns the pre-write contents.
    always_comb begin
        w_rd_a = w_old_a;
        w_rd_b = w_old_b;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(depth); i++) begin
                r_mem[i] <= '0;
            end
            r_q_a <= '0;
            r_q_b <= '0;
        end else begin
            if (w_wr_a) begin
                r_mem[addr_a] <= data_a;
            end
            if (w_wr_b) begin
                r_mem[addr_b] <= data_b;
            end
            r_q_a <= w_rd_a;
            r_q_b <= w_rd_b;
        end
    end

    assign q_a = r_q_a;
    assign q_b = r_q_b;

endmodule

// File: tb/tb_para_dual.sv
module tb_para_dual;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 36;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr_a = '0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic          wr_a = 1'b0;
    logic          wr_b = 1'b0;
    logic [DW-1:0] q_a;
    logic [DW-1:0] q_b;

    int total = 0;
    int bad   = 0;

    // Reference model: plain word array plus the values each port should show.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q_a = '0;
    logic [DW-1:0] exp_q_b = '0;

    para_dual #(
        .addr_width(AW),
        .data_width(DW),
        .depth     (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr_a(addr_a),
        .addr_b(addr_b),
        .data_a(data_a),
        .data_b(data_b),
        .wr_a  (wr_a),
        .wr_b  (wr_b),
        .q_a   (q_a),
        .q_b   (q_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic wa,
                         input logic [AW-1:0] ab, input logic [DW-1:0] db, input logic wb);
        addr_a = aa; data_a = da; wr_a = wa;
        addr_b = ab; data_b = db; wr_b = wb;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_q_a = '0;
        exp_q_b = '0;
    endtask

    // One rising edge: update the model from the inputs seen at the edge, then
    // settle 1 time unit so outputs are sampled away from the edge.
    task automatic step();
        bit a_ok, b_ok;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            a_ok = (int'(addr_a) < DEPTH);
            b_ok = (int'(addr_b) < DEPTH);
            exp_q_a = a_ok ? model[addr_a] : '0;
            exp_q_b = b_ok ? model[addr_b] : '0;
`ifdef PARA_DUAL_WRITE_FIRST_EN
            if (wr_a && a_ok) exp_q_a = data_a;
            if (wr_b && b_ok) exp_q_b = data_b;
`endif
            if (wr_b && b_ok && !(wr_a && a_ok && addr_a == addr_b)) model[addr_b] = data_b;
            if (wr_a && a_ok) model[addr_a] = data_a;
        end
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        model_clear();
        for (int i = 0; i < 10; i++) begin
            drive(AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                  1'($urandom));
            step();
            total++;
            if (q_a !== 8'h00) begin
                bad++; $display("FAIL reset_hold_q_a cyc=%0d got=%h exp=00", i, q_a);
            end
            total++;
            if (q_b !== 8'h00) begin
                bad++; $display("FAIL reset_hold_q_b cyc=%0d got=%h exp=00", i, q_b);
            end
        end
        reset = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            drive(AW'(a), DW'($urandom), 1'b0, AW'(DEPTH - 1 - a), DW'($urandom), 1'b0);
            step();
            total++;
            if (q_a !== 8'h00) begin
                bad++; $display("FAIL reset_sweep_q_a addr=%0d got=%h exp=00", a, q_a);
            end
            total++;
            if (q_b !== 8'h00) begin
                bad++; $display("FAIL reset_sweep_q_b addr=%0d got=%h exp=00", DEPTH - 1 - a, q_b);
            end
        end
    endtask

    task automatic test_dual_write();
        drive(6'd5, 8'hAB, 1'b1, 6'd10, 8'h44, 1'b1);
        step();
        drive(6'd5, 8'hCC, 1'b1, 6'd10, 8'h28, 1'b1);
        step();
        total++;
        if (q_a !== exp_q_a || q_b !== exp_q_b) begin
            bad++;
            $display("FAIL dual_overwrite got a=%h b=%h exp a=%h b=%h", q_a, q_b, exp_q_a, exp_q_b);
        end
        drive(6'd5, 8'h00, 1'b0, 6'd10, 8'h00, 1'b0);
        step();
        total++;
        if (q_a !== 8'hCC) begin
            bad++; $display("FAIL dual_read_q_a got=%h exp=cc", q_a);
        end
        total++;
        if (q_b !== 8'h28) begin
            bad++; $display("FAIL dual_read_q_b got=%h exp=28", q_b);
        end
    endtask

    task automatic test_cross_read();
        drive(6'd0, 8'h00, 1'b0, 6'd3, 8'h96, 1'b1);
        step();
        drive(6'd3, 8'h5A, 1'b1, 6'd3, 8'h00, 1'b0);
        step();
        total++;
        if (q_b !== 8'h96) begin
            bad++; $display("FAIL cross_old_q_b got=%h exp=96", q_b);
        end
        drive(6'd0, 8'h00, 1'b0, 6'd3, 8'h00, 1'b0);
        step();
        total++;
        if (q_b !== 8'h5A) begin
            bad++; $display("FAIL cross_new_q_b got=%h exp=5a", q_b);
        end
    endtask

    task automatic test_collision();
        drive(6'd7, 8'h11, 1'b1, 6'd7, 8'h22, 1'b1);
        step();
        total++;
        if (q_a !== exp_q_a || q_b !== exp_q_b) begin
            bad++;
            $display("FAIL collide_edge got a=%h b=%h exp a=%h b=%h", q_a, q_b, exp_q_a, exp_q_b);
        end
        drive(6'd7, 8'h00, 1'b0, 6'd7, 8'h00, 1'b0);
        step();
        total++;
        if (q_a !== 8'h11) begin
            bad++; $display("FAIL collide_q_a got=%h exp=11", q_a);
        end
        total++;
        if (q_b !== 8'h11) begin
            bad++; $display("FAIL collide_q_b got=%h exp=11", q_b);
        end
    endtask

    task automatic test_out_of_range();
        drive(6'd40, 8'hFF, 1'b1, 6'd63, 8'hEE, 1'b1);
        step();
        drive(6'd40, 8'h00, 1'b0, 6'd40, 8'h00, 1'b0);
        step();
        total++;
        if (q_a !== 8'h00 || q_b !== 8'h00) begin
            bad++; $display("FAIL oor_read got a=%h b=%h exp a=00 b=00", q_a, q_b);
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(AW'(a), 8'h00, 1'b0, AW'(a), 8'h00, 1'b0);
            step();
            total++;
            if (q_a !== model[a] || q_b !== model[a]) begin
                bad++;
                $display("FAIL oor_sweep addr=%0d got a=%h b=%h exp=%h", a, q_a, q_b, model[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(6'd20, 8'h3C, 1'b1, 6'd21, 8'hC3, 1'b1);
        step();
        drive(6'd20, 8'h00, 1'b0, 6'd21, 8'h00, 1'b0);
        step();
        total++;
        if (q_a !== 8'h3C || q_b !== 8'hC3) begin
            bad++; $display("FAIL premid_read got a=%h b=%h exp a=3c b=c3", q_a, q_b);
        end
        drive(6'd20, 8'h99, 1'b1, 6'd21, 8'h66, 1'b1);
        #2 reset = 1'b0;
        model_clear();
        #1;
        total++;
        if (q_a !== 8'h00 || q_b !== 8'h00) begin
            bad++; $display("FAIL mid_reset_async got a=%h b=%h exp a=00 b=00", q_a, q_b);
        end
        step();
        step();
        reset = 1'b1;
        drive(6'd20, 8'h00, 1'b0, 6'd21, 8'h00, 1'b0);
        step();
        total++;
        if (q_a !== 8'h00 || q_b !== 8'h00) begin
            bad++; $display("FAIL mid_reset_mem20_21 got a=%h b=%h exp a=00 b=00", q_a, q_b);
        end
        drive(6'd5, 8'h00, 1'b0, 6'd7, 8'h00, 1'b0);
        step();
        total++;
        if (q_a !== 8'h00 || q_b !== 8'h00) begin
            bad++; $display("FAIL mid_reset_mem5_7 got a=%h b=%h exp a=00 b=00", q_a, q_b);
        end
    endtask

    task automatic test_read_during_write();
        logic [DW-1:0] want_a;
        logic [DW-1:0] want_b;
`ifdef PARA_DUAL_WRITE_FIRST_EN
        want_a = 8'h77;
        want_b = 8'h88;
`else
        want_a = 8'h33;
        want_b = 8'h44;
`endif
        drive(6'd12, 8'h33, 1'b1, 6'd13, 8'h44, 1'b1);
        step();
        drive(6'd12, 8'h77, 1'b1, 6'd13, 8'h88, 1'b1);
        step();
        total++;
        if (q_a !== want_a) begin
            bad++; $display("FAIL rdw_q_a got=%h exp=%h", q_a, want_a);
        end
        total++;
        if (q_b !== want_b) begin
            bad++; $display("FAIL rdw_q_b got=%h exp=%h", q_b, want_b);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        for (int i = 0; i < 400; i++) begin
            aa = AW'($urandom_range(0, 45));
            ab = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, 45));
            drive(aa, DW'($urandom), 1'($urandom), ab, DW'($urandom), 1'($urandom));
            step();
            total++;
            if (q_a !== exp_q_a) begin
                bad++; $display("FAIL rand_q_a cyc=%0d got=%h exp=%h", i, q_a, exp_q_a);
            end
            total++;
            if (q_b !== exp_q_b) begin
                bad++; $display("FAIL rand_q_b cyc=%0d got=%h exp=%h", i, q_b, exp_q_b);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_dual_write();
        test_cross_read();
        test_collision();
        test_out_of_range();
        test_read_during_write();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
